// File: rtl/uc_ctrl.sv
// uc_ctrl: single-cycle CPU control unit with run/step/halt sequencing and a saturating instruction counter
module uc_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       Opcode,
  input  logic             z,
  input  logic             start,
  input  logic             step,
  output logic             s_inc,
  output logic             s_inm,
  output logic             we3,
  output logic             s_skip,
  output logic [2:0]       Op,
  output logic             pc_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] icount
);
  typedef enum logic [1:0] {IDLE, RUN, STEP, HALT} state_t;
  state_t state, state_nx;
  logic [2:0] cls;
  logic halt_op, exec;
  assign cls = Opcode[5:3];
  assign halt_op = cls == 3'b111;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = start ? RUN : step ? STEP : IDLE;
      RUN:  state_nx = halt_op ? HALT : RUN;
      STEP: state_nx = halt_op ? HALT : IDLE;
      HALT: state_nx = HALT;
      default: state_nx = IDLE;
    endcase
  end
  // Gating with reset keeps outputs safe even before the state register settles.
  always_comb begin
    exec = reset && (state == RUN || state == STEP) && !halt_op;
    we3 = exec && (cls == 3'b000 || cls == 3'b001);
    s_inm = exec && cls == 3'b001;
    s_inc = !(exec && cls == 3'b010);
    s_skip = exec && ((cls == 3'b011 && z) || (cls == 3'b100 && !z));
    Op = !exec ? 3'b000 : cls == 3'b000 ? Opcode[2:0] : (cls == 3'b011 || cls == 3'b100) ? 3'b011 : 3'b000;
    pc_en = exec;
    busy = state == RUN || state == STEP;
    halted = state == HALT;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) icount <= '0;
    else if (exec && icount != '1) icount <= icount + 1'b1;
endmodule
